// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-drain UART transmitter.
// Holds the FSM state encoding and default word/bit-time parameters.
package fifo_uart_pkg;

  localparam int DEF_DSIZE        = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    LOAD  = ST_LOAD,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled.
// Ports: clk, rst (sync, active-low), clear, enable -> tick on last count.
module bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  assign tick = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a FIFO one word at a time onto an 8N1 LSB-first serial line.
// Ports: clk, rst (sync active-low), buf_empty, buf_out -> r_e, tx, busy, tx_done, frame_count.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DSIZE        = DEF_DSIZE,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             buf_empty,
  input  logic [DSIZE-1:0] buf_out,
  output logic             r_e,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [7:0]       frame_count
);

  localparam int IW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DSIZE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DSIZE-1:0] r_shift;
  logic [IW-1:0]    r_idx;
  logic [7:0]       r_count;
  logic             w_tick;
  logic             w_clear;
  logic             w_en;

  assign w_clear = (r_state == LOAD);
  assign w_en    = (r_state == START) ||
                   (r_state == DATA)  ||
                   (r_state == STOP);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .enable(w_en),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD) begin
        r_shift <= buf_out;
        r_idx   <= '0;
      end else if (r_state == DATA && w_tick) begin
        r_shift <= r_shift >> 1;
        r_idx   <= r_idx + IW'(1);
      end
      if (r_state == STOP && w_tick) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // Outputs decode state/timer only; buf_empty steers next state alone.
  always_comb begin
    w_next  = r_state;
    tx      = 1'b1;
    r_e     = 1'b0;
    tx_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!buf_empty) w_next = READ;
      end
      READ: begin
        r_e    = 1'b1;
        w_next = LOAD;
      end
      LOAD: begin
        w_next = START;
      end
      START: begin
        tx = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        tx = r_shift[0];
        if (w_tick && r_idx == LAST_BIT) w_next = STOP;
      end
      STOP: begin
        tx_done = w_tick;
        if (w_tick) w_next = buf_empty ? IDLE : READ;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign busy        = (r_state != IDLE);
  assign frame_count = r_count;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a behavioural FIFO source.
// Table-driven single frames plus directed reset/back-to-back/late/wrap sequences.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       buf_empty;
  logic [7:0] buf_out = 8'h00;
  logic       r_e;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DSIZE(8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buf_empty  (buf_empty),
    .buf_out    (buf_out),
    .r_e        (r_e),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .frame_count(frame_count)
  );

  // Behavioural FIFO: registered read data, valid the cycle after r_e.
  logic [7:0] mem [0:1023];
  int wr = 0;
  int rd = 0;
  assign buf_empty = (wr == rd);

  always @(posedge clk) begin
    if (r_e && rd < wr) begin
      buf_out <= mem[rd % 1024];
      rd      <= rd + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr % 1024] = d;
    wr++;
  endtask

  // Monitor: pulse counts, underflow rule, count/done coincidence.
  int   n_re = 0;
  int   n_done = 0;
  int   re_viol = 0;
  int   fc_bad = 0;
  bit   wrap_seen = 1'b0;
  logic last_empty = 1'b1;
  logic [7:0] p_fc = 8'h00;
  logic p_done = 1'b0;
  logic p_rst = 1'b0;

  always @(posedge clk) begin
    if (r_e) n_re <= n_re + 1;
    if (tx_done) n_done <= n_done + 1;
    if (r_e && last_empty) re_viol <= re_viol + 1;
    if (p_rst && frame_count !== 8'(p_fc + 8'(p_done)))
      fc_bad <= fc_bad + 1;
    if (p_rst && p_fc == 8'hFF && frame_count == 8'h00)
      wrap_seen <= 1'b1;
    last_empty <= buf_empty;
    p_fc       <= frame_count;
    p_done     <= tx_done;
    p_rst      <= rst;
  end

  // Capture one frame: waitc = negedges until start bit seen.
  task automatic rx(output logic [9:0] got, output int waitc,
                    output bit stable, output bit done_last,
                    output bit busy_lo);
    got = '0;
    waitc = 0;
    stable = 1'b1;
    done_last = 1'b0;
    busy_lo = 1'b0;
    do begin
      @(negedge clk);
      waitc++;
      if (!busy) busy_lo = 1'b1;
    end while (tx !== 1'b0 && waitc < 400);
    if (tx !== 1'b0) return;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) @(negedge clk);
      if (!busy) busy_lo = 1'b1;
      if (i % CPB == 0) got[i / CPB] = tx;
      else if (tx !== got[i / CPB]) stable = 1'b0;
      if (i == NB - 1) done_last = tx_done;
      else if (tx_done) stable = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [9:0] got;
    int   wc;
    int   exp_fc;
    int   re0;
    int   d0;
    int   errs;
    bit   st;
    bit   dl;
    bit   bl;
    bit   f_re;
    bit   f_tx;
    bit   f_busy;
    logic [7:0] b;

    // Frame bits in transmit order: {stop, data[7:0], start}.
    tbl[0] = '{d: 8'hA5, f: 10'h34A};
    tbl[1] = '{d: 8'h81, f: 10'h302};
    tbl[2] = '{d: 8'h5A, f: 10'h2B4};
    tbl[3] = '{d: 8'h01, f: 10'h202};
    exp_fc = 0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_re", r_e, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_fc", frame_count, 0);
    rst = 1'b1;

    // Empty FIFO for 100 cycles.
    f_re = 0; f_tx = 0; f_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (r_e) f_re = 1;
      if (tx !== 1'b1) f_tx = 1;
      if (busy) f_busy = 1;
    end
    chk("empty_re", f_re, 0);
    chk("empty_tx", f_tx, 0);
    chk("empty_busy", f_busy, 0);

    // Reset during data bit 3 of 0x5A; 0x81 stays queued.
    push(8'h5A);
    push(8'h81);
    wc = 0;
    do begin
      @(negedge clk);
      wc++;
    end while (tx !== 1'b0 && wc < 400);
    chk("mid_start", tx, 0);
    repeat (17) @(negedge clk);
    d0  = n_done;
    re0 = n_re;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_tx", tx, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", tx_done, 0);
    chk("mid_fc", frame_count, 8'(exp_fc));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("mid_ndone", n_done - d0, 0);
    chk("mid_nre", n_re - re0, 0);
    rx(got, wc, st, dl, bl);
    exp_fc++;
    chk("mid_next", got, 10'h302);
    chk("mid_stable", st, 1);
    @(negedge clk);
    chk("mid_fc2", frame_count, 8'(exp_fc));

    // Single frames from a table, each into an empty FIFO.
    foreach (tbl[k]) begin
      re0 = n_re;
      push(tbl[k].d);
      rx(got, wc, st, dl, bl);
      exp_fc++;
      chk($sformatf("v%0d_frame", k), got, tbl[k].f);
      chk($sformatf("v%0d_lat", k), wc, 3);
      chk($sformatf("v%0d_stable", k), st, 1);
      chk($sformatf("v%0d_done", k), dl, 1);
      @(negedge clk);
      chk($sformatf("v%0d_fc", k), frame_count, 8'(exp_fc));
      chk($sformatf("v%0d_nre", k), n_re - re0, 1);
    end

    // Back-to-back frames.
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    for (int k = 0; k < 3; k++) begin
      rx(got, wc, st, dl, bl);
      exp_fc++;
      case (k)
        0: chk("b2b0_frame", got, 10'h200);
        1: chk("b2b1_frame", got, 10'h3FE);
        default: chk("b2b2_frame", got, 10'h278);
      endcase
      chk($sformatf("b2b%0d_stable", k), st, 1);
      if (k > 0) begin
        chk($sformatf("b2b%0d_gap", k), wc - 1, 2);
        chk($sformatf("b2b%0d_busylo", k), bl, 0);
      end
    end
    @(negedge clk);
    chk("b2b_fc", frame_count, 8'(exp_fc));

    // Late arrival: in the last stop cycle, then one cycle later.
    push(8'hC3);
    rx(got, wc, st, dl, bl);
    exp_fc++;
    chk("late0_frame", got, 10'h386);
    push(8'h96);
    rx(got, wc, st, dl, bl);
    exp_fc++;
    chk("late1_frame", got, 10'h32C);
    chk("late1_gap", wc - 1, 2);
    @(negedge clk);
    push(8'h18);
    rx(got, wc, st, dl, bl);
    exp_fc++;
    chk("late2_frame", got, 10'h230);
    chk("late2_gap", wc, 3);
    @(negedge clk);
    chk("late_fc", frame_count, 8'(exp_fc));

    // 256 frames to wrap the counter.
    re0  = n_re;
    d0   = n_done;
    errs = 0;
    for (int i = 0; i < 256; i++) push(8'(i));
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      rx(got, wc, st, dl, bl);
      exp_fc++;
      if (got !== {1'b1, b, 1'b0} || !st || !dl) errs++;
    end
    @(negedge clk);
    chk("wrap_frames", errs, 0);
    chk("wrap_nre", n_re - re0, 256);
    chk("wrap_ndone", n_done - d0, 256);
    chk("wrap_seen", wrap_seen, 1);
    chk("wrap_fc", frame_count, 8'(exp_fc));
    chk("re_underflow", re_viol, 0);
    chk("fc_vs_done", fc_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
